// File: rtl/sdr_port_arbiter_if.sv
// Request/response and controller command signals around sdr_port_arbiter.
// slave is the arbiter's view; master is the requesters-plus-controller view.
interface sdr_port_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_write;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        rsp_err;
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_write;
  logic [ADDR_W-1:0]           cmd_addr;
  logic [DATA_W-1:0]           cmd_wdata;
  logic                        cmd_done;
  logic [DATA_W-1:0]           cmd_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, cmd_ready, cmd_done, cmd_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, cmd_valid, cmd_write, cmd_addr, cmd_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, cmd_ready, cmd_done, cmd_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, cmd_valid, cmd_write, cmd_addr, cmd_wdata
  );
endinterface

// File: rtl/sdr_port_arbiter.sv
// Arbitrates NUM_PORTS requesters onto the SDR controller command port, one command in flight.
// Define SDR_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority, lowest index wins.
module sdr_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              init_done,
  sdr_port_arbiter_if.slave bus,
  output logic [2:0]        grant_id,
  output logic              busy
);
  localparam int                   PTR_W    = $clog2(NUM_PORTS);
  localparam logic [7:0]           TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [NUM_PORTS-1:0] ONE      = NUM_PORTS'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  win_q, win_d;
  logic              found;
  logic              accept;
  logic [7:0]        tmo_q;
  logic              cmd_write_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

`ifdef SDR_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] rr_ptr_q;
  int               rr_idx;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    found  = 1'b0;
    win_d  = '0;
    rr_idx = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rr_idx = int'(rr_ptr_q) + i;
      if (rr_idx >= NUM_PORTS) rr_idx = rr_idx - NUM_PORTS;
      if (!found && bus.req_valid[rr_idx]) begin
        found = 1'b1;
        win_d = PTR_W'(rr_idx);
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rr_ptr_q <= '0;
    end else if (state_q == RESP) begin
      rr_ptr_q <= (win_q == PTR_W'(NUM_PORTS - 1)) ? '0 : win_q + 1'b1;
    end
  end
`else
  // Scanning downward lets the lowest requesting index overwrite any higher one.
  always_comb begin
    found = 1'b0;
    win_d = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        found = 1'b1;
        win_d = PTR_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE:  if (init_done && found) begin
               accept  = 1'b1;
               state_d = ISSUE;
             end
      ISSUE: if (bus.cmd_ready) state_d = WAIT;
      WAIT:  if (bus.cmd_done || tmo_q == TMO_LAST) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      win_q       <= '0;
      tmo_q       <= '0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        win_q       <= win_d;
        cmd_write_q <= bus.req_write[win_d];
        cmd_addr_q  <= bus.req_addr[win_d*ADDR_W +: ADDR_W];
        cmd_wdata_q <= bus.req_wdata[win_d*DATA_W +: DATA_W];
      end

      if (state_q == ISSUE && bus.cmd_ready) tmo_q <= '0;
      else if (state_q == WAIT)              tmo_q <= tmo_q + 8'd1;

      // A completion arriving on the timeout cycle still counts as a clean finish.
      if (state_q == WAIT) begin
        if (bus.cmd_done) begin
          rsp_rdata_q <= cmd_write_q ? '0 : bus.cmd_rdata;
          rsp_err_q   <= 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
        end
      end
    end
  end

  // req_ready is the only combinational output; it is forced low while reset is held.
  assign bus.req_ready = (accept && !preset) ? (ONE << win_d) : '0;
  assign bus.rsp_valid = (state_q == RESP) ? (ONE << win_q) : '0;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.cmd_valid = (state_q == ISSUE);
  assign bus.cmd_write = cmd_write_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.cmd_wdata = cmd_wdata_q;
  assign grant_id      = 3'(win_q);
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_sdr_port_arbiter.sv
// Self-checking bench for sdr_port_arbiter: vector table plus hand sequences, scoreboarded responses.
// Works for both builds; SDR_ARB_ROUND_ROBIN_EN selects the expected grant order.
module tb_sdr_port_arbiter;
  localparam int NP  = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic       pclk = 1'b0;
  logic       preset;
  logic       init_done;
  logic [2:0] grant_id;
  logic       busy;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int            port;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  typedef struct {
    int            port;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd;
    int            rdy_dly;
    int            done_dly;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  rsp_t sb[$];
  vec_t vecs[6];
  int   exp_order[5];

  sdr_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sdr_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .init_done (init_done),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected end earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_rsp(input string tag);
    rsp_t          e;
    logic [NP-1:0] oh;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got unexpected response 0x%0h expected none", tag, bus.rsp_valid);
      return;
    end
    e  = sb.pop_front();
    oh = NP'(1) << e.port;
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(oh));
    check({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'(e.rdata));
    check({tag, " rsp_err"},   32'(bus.rsp_err),   32'(e.err));
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int            t_acc;
    int            n;
    logic [NP-1:0] oh;
    rsp_t          e;
    oh = NP'(1) << v.port;
    bus.req_valid = oh;
    bus.req_write[v.port] = v.wr;
    bus.req_addr[v.port*AW +: AW]  = v.addr;
    bus.req_wdata[v.port*DW +: DW] = v.wdata;
    #1;
    n = 0;
    while (bus.req_ready !== oh && n < 50) begin
      step();
      n++;
    end
    check({tag, " accept"}, 32'(bus.req_ready), 32'(oh));
    if (bus.req_ready !== oh) begin
      bus.req_valid = '0;
      return;
    end
    t_acc   = cyc;
    e.port  = v.port;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    step();
    bus.req_valid = '0;
    for (int k = 0; k <= v.rdy_dly; k++) begin
      check({tag, " cmd_valid"}, 32'(bus.cmd_valid), 32'd1);
      check({tag, " cmd_addr"},  32'(bus.cmd_addr),  32'(v.addr));
      check({tag, " cmd_write"}, 32'(bus.cmd_write), 32'(v.wr));
      check({tag, " grant_id"},  32'(grant_id),      32'(v.port));
      if (v.wr) check({tag, " cmd_wdata"}, 32'(bus.cmd_wdata), 32'(v.wdata));
      bus.cmd_ready = (k == v.rdy_dly);
      // Stray completions while the command is still being offered must be ignored.
      bus.cmd_done  = (k != v.rdy_dly);
      step();
    end
    bus.cmd_ready = 1'b0;
    bus.cmd_done  = 1'b0;
    check({tag, " cmd_valid wait"}, 32'(bus.cmd_valid), 32'd0);
    for (int d = 0; d < 300 && bus.rsp_valid == '0; d++) begin
      bus.cmd_done  = (d == v.done_dly);
      bus.cmd_rdata = (d == v.done_dly) ? v.rd : 16'hDEAD;
      step();
    end
    bus.cmd_done = 1'b0;
    check({tag, " latency"}, 32'(cyc - t_acc), 32'(v.exp_lat));
    check_rsp(tag);
    step();
    check({tag, " rsp pulse"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int t_prev;
    int cnt;
    rsp_t e;
    vec_t fresh;

    // port wr addr wdata rd rdy_dly done_dly exp_rdata exp_err exp_lat
    vecs[0] = '{2, 1'b1, 16'h0123, 16'hBEEF, 16'h9999, 0, 0, 16'h0000, 1'b0, 3};
    vecs[1] = '{1, 1'b0, 16'h0040, 16'h0000, 16'h5A5A, 0, 6, 16'h5A5A, 1'b0, 9};
    vecs[2] = '{3, 1'b0, 16'h7FFF, 16'h0000, 16'h1234, 0, 7, 16'h1234, 1'b0, 10};
    vecs[3] = '{0, 1'b0, 16'h0001, 16'h0000, 16'h4321, 0, 8, 16'h0000, 1'b1, 10};
    vecs[4] = '{1, 1'b1, 16'hFFFF, 16'h0001, 16'hAAAA, 2, 2, 16'h0000, 1'b0, 7};
    vecs[5] = '{0, 1'b0, 16'h8000, 16'h0000, 16'h0F0F, 1, 3, 16'h0F0F, 1'b0, 7};
`ifdef SDR_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif

    preset        = 1'b1;
    init_done     = 1'b0;
    bus.req_valid = '1;
    bus.req_write = '0;
    bus.req_wdata = '0;
    for (int p = 0; p < NP; p++) bus.req_addr[p*AW +: AW] = 16'h0100 + 16'(p);
    bus.cmd_ready = 1'b0;
    bus.cmd_done  = 1'b0;
    bus.cmd_rdata = '0;

    // Reset values, and no grants while init_done is low.
    repeat (2) step();
    check("rst req_ready", 32'(bus.req_ready), 32'd0);
    check("rst cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst busy",      32'(busy),          32'd0);
    check("rst grant_id",  32'(grant_id),      32'd0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst rsp_err",   32'(bus.rsp_err),   32'd0);
    check("rst cmd_addr",  32'(bus.cmd_addr),  32'd0);
    @(negedge pclk);
    preset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("noinit req_ready", 32'(bus.req_ready), 32'd0);
      check("noinit cmd_valid", 32'(bus.cmd_valid), 32'd0);
    end

    // All ports requesting continuously: grant order and 4-cycle throughput.
    init_done = 1'b1;
    #1;
    check("init req_ready", 32'(bus.req_ready), 32'd1);
    t_prev = cyc;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (!bus.cmd_valid && n < 20) begin
        step();
        n++;
      end
      check("rr cmd_valid", 32'(bus.cmd_valid), 32'd1);
      check("rr grant_id",  32'(grant_id),      32'(exp_order[g]));
      check("rr cmd_addr",  32'(bus.cmd_addr),  32'h0100 + 32'(exp_order[g]));
      check("rr spacing",   32'(cyc - t_prev),  (g == 0) ? 32'd1 : 32'd4);
      t_prev  = cyc;
      e.port  = exp_order[g];
      e.rdata = 16'h1000 + 16'(g);
      e.err   = 1'b0;
      sb.push_back(e);
      if (g == 4) bus.req_valid = '0;
      bus.cmd_ready = 1'b1;
      step();
      bus.cmd_ready = 1'b0;
      bus.cmd_done  = 1'b1;
      bus.cmd_rdata = 16'h1000 + 16'(g);
      step();
      bus.cmd_done = 1'b0;
      check_rsp("rr");
    end
    step();

    // A request withdrawn before any grant is never serviced.
    init_done = 1'b0;
    bus.req_valid = 4'b0100;
    repeat (2) step();
    check("drop req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    init_done = 1'b1;
    repeat (2) step();
    check("drop busy",      32'(busy),          32'd0);
    check("drop cmd_valid", 32'(bus.cmd_valid), 32'd0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Late completion while idle changes nothing.
    bus.cmd_done = 1'b1;
    step();
    bus.cmd_done = 1'b0;
    check("late done busy",      32'(busy),          32'd0);
    check("late done rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    check("late done rsp_valid2", 32'(bus.rsp_valid), 32'd0);

    // Reset asserted during WAIT abandons the command.
    bus.req_valid = 4'b1000;
    bus.req_write[3] = 1'b0;
    bus.req_addr[3*AW +: AW] = 16'h0333;
    #1;
    check("rstw accept", 32'(bus.req_ready), 32'b1000);
    step();
    bus.req_valid = '0;
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
    check("rstw busy",     32'(busy),     32'd1);
    check("rstw grant_id", 32'(grant_id), 32'd3);
    step();
    bus.req_valid = 4'b0001;
    #2;
    preset = 1'b1;
    #1;
    check("rstw busy0",      32'(busy),          32'd0);
    check("rstw grant0",     32'(grant_id),      32'd0);
    check("rstw cmd_addr0",  32'(bus.cmd_addr),  32'd0);
    check("rstw rsp_rdata0", 32'(bus.rsp_rdata), 32'd0);
    check("rstw req_ready0", 32'(bus.req_ready), 32'd0);
    check("rstw rsp_valid0", 32'(bus.rsp_valid), 32'd0);
    step();
    bus.req_valid = '0;
    @(negedge pclk);
    preset = 1'b0;
    cnt = 0;
    bus.cmd_done = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      bus.cmd_done = 1'b0;
      if (bus.rsp_valid != '0) cnt++;
    end
    check("rstw no response", 32'(cnt), 32'd0);

    fresh = '{3, 1'b0, 16'h0ACE, 16'h0000, 16'hC0DE, 0, 1, 16'hC0DE, 1'b0, 4};
    run_txn(fresh, "fresh");
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
